// File: rtl/qed_dup_encoder.sv
// QED duplicate encoder: buffers each fetched instruction, emits it once,
// then emits a shadow-register copy (x16..x31) for duplicable opcodes.
module qed_dup_encoder #(
  parameter int CNT_W     = 16,
  parameter bit DUP_LOADS = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             qed_enable_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_instr_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [31:0]      out_instr_o,
  output logic             out_is_dup_o,
  input  logic             out_ready_i,
  output logic             violation_o,
  output logic [CNT_W-1:0] dup_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ORIG,
    S_DUP
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_e           state_q, state_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [31:0]      dup_instr_q, dup_instr_d;
  logic             out_is_dup_q, out_is_dup_d;
  logic             dup_flag_q, dup_flag_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        dupable;
  logic        viol_hit;
  logic [31:0] remap;
  logic        last_beat;
  logic        accept;
  logic        out_hs;

  // Which register fields this opcode would move into the shadow half.
  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dupable = 1'b0;
    unique case (in_instr_i[6:0])
      OP_R: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dupable = 1'b1;
      end
      OP_IALU: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        dupable = 1'b1;
      end
      OP_LOAD: begin
        use_rd  = DUP_LOADS;
        use_rs1 = DUP_LOADS;
        dupable = DUP_LOADS;
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dupable = 1'b1;
      end
      OP_LUI: begin
        use_rd  = 1'b1;
        dupable = 1'b1;
      end
      default: begin
        dupable = 1'b0;
      end
    endcase
  end

  always_comb begin
    viol_hit = (use_rd  & in_instr_i[11])
             | (use_rs1 & in_instr_i[19])
             | (use_rs2 & in_instr_i[24]);
    remap = in_instr_i;
    if (use_rd && (in_instr_i[11:7] != 5'd0)) begin
      remap[11] = 1'b1;
    end
    if (use_rs1 && (in_instr_i[19:15] != 5'd0)) begin
      remap[19] = 1'b1;
    end
    if (use_rs2 && (in_instr_i[24:20] != 5'd0)) begin
      remap[24] = 1'b1;
    end
  end

  always_comb begin
    last_beat  = ((state_q == S_ORIG) && !dup_flag_q)
               || (state_q == S_DUP);
    in_ready_o = (state_q == S_EMPTY)
               || (out_ready_i && last_beat);
    accept     = in_valid_i && in_ready_o;
    out_hs     = (state_q != S_EMPTY) && out_ready_i;
  end

  always_comb begin
    state_d      = state_q;
    out_instr_d  = out_instr_q;
    dup_instr_d  = dup_instr_q;
    out_is_dup_d = out_is_dup_q;
    dup_flag_d   = dup_flag_q;
    viol_d       = 1'b0;
    cnt_d        = cnt_q;
    if (out_hs && (state_q == S_DUP)) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    if (out_hs && (state_q == S_ORIG) && dup_flag_q) begin
      state_d      = S_DUP;
      out_instr_d  = dup_instr_q;
      out_is_dup_d = 1'b1;
    end else if (accept) begin
      state_d      = S_ORIG;
      out_instr_d  = in_instr_i;
      dup_instr_d  = remap;
      out_is_dup_d = 1'b0;
      dup_flag_d   = qed_enable_i & dupable & ~viol_hit;
      viol_d       = qed_enable_i & dupable & viol_hit;
    end else if (out_hs) begin
      state_d      = S_EMPTY;
      out_is_dup_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_EMPTY;
      out_instr_q  <= 32'd0;
      dup_instr_q  <= 32'd0;
      out_is_dup_q <= 1'b0;
      dup_flag_q   <= 1'b0;
      viol_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      out_instr_q  <= out_instr_d;
      dup_instr_q  <= dup_instr_d;
      out_is_dup_q <= out_is_dup_d;
      dup_flag_q   <= dup_flag_d;
      viol_q       <= viol_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid_o  = (state_q != S_EMPTY);
  assign out_instr_o  = out_instr_q;
  assign out_is_dup_o = out_is_dup_q;
  assign violation_o  = viol_q;
  assign dup_cnt_o    = cnt_q;

endmodule
